claw_round_controller: RTL and testbench

//  Level sequencer for the claw datapath. Issues start_level and gates the enter key into a single launch pulse.

---
 rtl/claw_round_controller.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_claw_round_controller.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/claw_round_controller.sv
// claw_round_controller
//   Level sequencer for the claw game datapath. It turns the raw enter key into
//   rising-edge events, issues the start_level pulse, hands a single launch pulse
//   to claw_move, picks the claw speed from the grabbed loot, adds loot value to
//   the score when the claw comes home and runs the per-level countdown that
//   decides between a win and a loss.
//
// Ports
//   clk               system clock
//   resetN            asynchronous active-low reset
//   startOfFrame      one-cycle pulse per video frame (timer time base)
//   enter_key         raw enter key level
//   claw_collision    claw touching loot or border
//   loot_type         object type, valid while claw_collision is high
//   claw_returned     claw back at the pivot
//   start_level       one-cycle pulse: restart claw and loot map
//   is_enter_pressed  one-cycle launch pulse to claw_move
//   move_speed        claw speed (1, 2, 4 or 8)
//   loot_grabbed      one-cycle pulse: hide the grabbed object
//   score             cumulative score, saturating at 16'hFFFF
//   time_left         seconds remaining in the level
//   level             current level index
//   level_won         high while the level is won
//   level_lost        high while the level is lost

module claw_round_controller #(
    parameter int unsigned FRAMES_PER_SEC = 30,
    parameter int unsigned LEVEL_TIME     = 60,
    parameter int unsigned TARGET_BASE    = 650,
    parameter int unsigned TARGET_STEP    = 350,
    parameter int unsigned MAX_LEVEL      = 9,
    parameter int unsigned DEFAULT_SPEED  = 4
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        enter_key,
    input  logic        claw_collision,
    input  logic [2:0]  loot_type,
    input  logic        claw_returned,
    output logic        start_level,
    output logic        is_enter_pressed,
    output logic [3:0]  move_speed,
    output logic        loot_grabbed,
    output logic [15:0] score,
    output logic [7:0]  time_left,
    output logic [3:0]  level,
    output logic        level_won,
    output logic        level_lost
);

    localparam int unsigned FrameCntW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [FrameCntW-1:0] FrameLast    = FrameCntW'(FRAMES_PER_SEC - 1);
    localparam logic [7:0]           LevelTime    = 8'(LEVEL_TIME);
    localparam logic [3:0]           DefaultSpeed = 4'(DEFAULT_SPEED);
    localparam logic [3:0]           MaxLevel     = 4'(MAX_LEVEL);
    localparam logic [15:0]          TargetBase   = 16'(TARGET_BASE);
    localparam logic [15:0]          TargetStep   = 16'(TARGET_STEP);

    typedef enum logic [2:0] {
        IdleSt,
        StartSt,
        SwingSt,
        ShootSt,
        EmptySt,
        PullSt,
        WinSt,
        LoseSt
    } state_e;

    // Loot table: claw speed while carrying each object type.
    function automatic logic [3:0] loot_speed(input logic [2:0] t);
        logic [3:0] s;
        case (t)
            3'd0:    s = 4'd8;
            3'd1:    s = 4'd4;
            3'd2:    s = 4'd1;
            3'd3:    s = 4'd8;
            3'd4:    s = 4'd2;
            3'd5:    s = 4'd1;
            3'd6:    s = 4'd4;
            default: s = 4'd4;
        endcase
        return s;
    endfunction

    // Loot table: score value of each object type.
    function automatic logic [9:0] loot_value(input logic [2:0] t);
        logic [9:0] v;
        case (t)
            3'd0:    v = 10'd0;
            3'd1:    v = 10'd50;
            3'd2:    v = 10'd500;
            3'd3:    v = 10'd600;
            3'd4:    v = 10'd20;
            3'd5:    v = 10'd10;
            3'd6:    v = 10'd100;
            default: v = 10'd0;
        endcase
        return v;
    endfunction

    state_e                 state_q, state_d;
    logic                   enter_q;
    logic [FrameCntW-1:0]   frame_q, frame_d;
    logic [7:0]             time_q, time_d;
    logic [15:0]            score_q, score_d;
    logic [3:0]             level_q, level_d;
    logic [3:0]             speed_q, speed_d;
    logic [2:0]             loot_q, loot_d;
    logic                   start_q, start_d;
    logic                   launch_q, launch_d;
    logic                   grab_q, grab_d;

    logic                   enter_edge;
    logic                   timer_active;
    logic                   expire;
    logic [FrameCntW-1:0]   frame_run;
    logic [7:0]             time_run;
    logic [16:0]            score_sum;
    logic [15:0]            score_add;
    logic [15:0]            score_fin;
    logic [15:0]            target;

    // Edge detect, scoring arithmetic and level target.
    always_comb begin
        enter_edge   = enter_key & ~enter_q;
        timer_active = (state_q == SwingSt) || (state_q == ShootSt) ||
                       (state_q == EmptySt) || (state_q == PullSt);
        score_sum    = {1'b0, score_q} + 17'(loot_value(loot_q));
        score_add    = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        target       = TargetBase + 16'(level_q) * TargetStep;
    end

    // Countdown: one second per FRAMES_PER_SEC frames; expiry is the step from 1 to 0.
    always_comb begin
        frame_run = frame_q;
        time_run  = time_q;
        expire    = 1'b0;
        if (timer_active && startOfFrame) begin
            if (frame_q == FrameLast) begin
                frame_run = '0;
                time_run  = time_q - 8'd1;
                expire    = (time_q == 8'd1);
            end else begin
                frame_run = frame_q + FrameCntW'(1);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_run;
        time_d    = time_run;
        score_d   = score_q;
        level_d   = level_q;
        speed_d   = speed_q;
        loot_d    = loot_q;
        start_d   = 1'b0;
        launch_d  = 1'b0;
        grab_d    = 1'b0;
        score_fin = score_q;

        if (expire) begin
            // A claw arriving home on the expiry cycle still scores before the compare;
            // anything still being pulled otherwise is dropped.
            if ((state_q == PullSt) && claw_returned) begin
                score_fin = score_add;
            end
            score_d = score_fin;
            speed_d = DefaultSpeed;
            state_d = (score_fin >= target) ? WinSt : LoseSt;
        end else begin
            case (state_q)
                IdleSt: begin
                    if (enter_edge) begin
                        state_d = StartSt;
                    end
                end
                StartSt: begin
                    start_d = 1'b1;
                    time_d  = LevelTime;
                    frame_d = '0;
                    speed_d = DefaultSpeed;
                    state_d = SwingSt;
                end
                SwingSt: begin
                    if (enter_edge) begin
                        launch_d = 1'b1;
                        state_d  = ShootSt;
                    end
                end
                ShootSt: begin
                    // A collision wins over a simultaneous return.
                    if (claw_collision) begin
                        loot_d  = loot_type;
                        speed_d = loot_speed(loot_type);
                        grab_d  = 1'b1;
                        if ((loot_type == 3'd0) || (loot_type == 3'd7)) begin
                            state_d = EmptySt;
                        end else begin
                            state_d = PullSt;
                        end
                    end else if (claw_returned) begin
                        speed_d = DefaultSpeed;
                        state_d = SwingSt;
                    end
                end
                EmptySt: begin
                    if (claw_returned) begin
                        speed_d = DefaultSpeed;
                        state_d = SwingSt;
                    end
                end
                PullSt: begin
                    if (claw_returned) begin
                        score_d = score_add;
                        speed_d = DefaultSpeed;
                        state_d = SwingSt;
                    end
                end
                WinSt: begin
                    if (enter_edge) begin
                        if (level_q < MaxLevel) begin
                            level_d = level_q + 4'd1;
                        end
                        state_d = StartSt;
                    end
                end
                LoseSt: begin
                    if (enter_edge) begin
                        level_d = 4'd0;
                        score_d = 16'd0;
                        state_d = StartSt;
                    end
                end
                default: begin
                    state_d = IdleSt;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IdleSt;
            enter_q  <= 1'b0;
            frame_q  <= '0;
            time_q   <= LevelTime;
            score_q  <= 16'd0;
            level_q  <= 4'd0;
            speed_q  <= DefaultSpeed;
            loot_q   <= 3'd0;
            start_q  <= 1'b0;
            launch_q <= 1'b0;
            grab_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            enter_q  <= enter_key;
            frame_q  <= frame_d;
            time_q   <= time_d;
            score_q  <= score_d;
            level_q  <= level_d;
            speed_q  <= speed_d;
            loot_q   <= loot_d;
            start_q  <= start_d;
            launch_q <= launch_d;
            grab_q   <= grab_d;
        end
    end

    always_comb begin
        start_level      = start_q;
        is_enter_pressed = launch_q;
        loot_grabbed     = grab_q;
        move_speed       = speed_q;
        score            = score_q;
        time_left        = time_q;
        level            = level_q;
        level_won        = (state_q == WinSt);
        level_lost       = (state_q == LoseSt);
    end

endmodule

// File: tb/tb_claw_round_controller.sv
// tb_claw_round_controller
//   Randomised bench for claw_round_controller. A game-level reference model
//   predicts each output event (start, launch, grab, win, loss) together with
//   the cycle it must appear in and the HUD values at that moment; a monitor
//   matches every pulse the DUT shows against the head of the expectation queue.

module tb_claw_round_controller;

    localparam int FPS  = 30;
    localparam int LT   = 60;
    localparam int BASE = 650;
    localparam int STEP = 350;
    localparam int MAXL = 9;
    localparam int DEF  = 4;

    localparam int KStart  = 0;
    localparam int KLaunch = 1;
    localparam int KGrab   = 2;
    localparam int KWin    = 3;
    localparam int KLose   = 4;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        sof = 1'b0;
    logic        enter = 1'b0;
    logic        col = 1'b0;
    logic        ret = 1'b0;
    logic [2:0]  ltype = 3'd0;

    logic        start_level;
    logic        is_enter_pressed;
    logic [3:0]  move_speed;
    logic        loot_grabbed;
    logic [15:0] score;
    logic [7:0]  time_left;
    logic [3:0]  level;
    logic        level_won;
    logic        level_lost;

    always #5 clk = ~clk;

    claw_round_controller dut (
        .clk              (clk),
        .resetN           (resetN),
        .startOfFrame     (sof),
        .enter_key        (enter),
        .claw_collision   (col),
        .loot_type        (ltype),
        .claw_returned    (ret),
        .start_level      (start_level),
        .is_enter_pressed (is_enter_pressed),
        .move_speed       (move_speed),
        .loot_grabbed     (loot_grabbed),
        .score            (score),
        .time_left        (time_left),
        .level            (level),
        .level_won        (level_won),
        .level_lost       (level_lost)
    );

    typedef struct {
        int kind;
        int cyc;
        int score;
        int level;
        int tleft;
        int speed;   // -1: not checked
    } ev_t;

    typedef enum int {PhIdle, PhStart, PhSwing, PhShoot, PhEmpty, PhPull, PhWin, PhLose} phase_e;

    ev_t    exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc_n  = 0;

    int spd_tab [8] = '{8, 4, 1, 8, 2, 1, 4, 4};
    int val_tab [8] = '{0, 50, 500, 600, 20, 10, 100, 0};

    // Game-level reference state.
    phase_e m_phase;
    int     m_score;
    int     m_level;
    int     m_frames;   // frames counted since the level started
    int     m_loot;
    bit     m_prev_en;

    function automatic void model_reset();
        m_phase   = PhIdle;
        m_score   = 0;
        m_level   = 0;
        m_frames  = 0;
        m_loot    = 0;
        m_prev_en = 1'b0;
    endfunction

    function automatic void push_ev(int kind, int spd);
        ev_t ev;
        ev.kind  = kind;
        ev.cyc   = cyc_n + 1;
        ev.score = m_score;
        ev.level = m_level;
        ev.tleft = LT - m_frames / FPS;
        ev.speed = spd;
        exp_q.push_back(ev);
    endfunction

    function automatic int add_sat(int a, int b);
        return (a + b > 65535) ? 65535 : a + b;
    endfunction

    // Applies one clock edge worth of game rules to the reference state.
    function automatic void model_step(bit en, bit c, int lt, bit r, bit s);
        bit e;
        bit expire;
        int tgt;
        e         = en && !m_prev_en;
        m_prev_en = en;
        expire    = 1'b0;
        if ((m_phase == PhSwing || m_phase == PhShoot || m_phase == PhEmpty ||
             m_phase == PhPull) && s) begin
            m_frames++;
            if (m_frames == FPS * LT) expire = 1'b1;
        end
        if (expire) begin
            if (m_phase == PhPull && r) m_score = add_sat(m_score, val_tab[m_loot]);
            tgt = (BASE + m_level * STEP) % 65536;
            if (m_score >= tgt) begin
                m_phase = PhWin;
                push_ev(KWin, -1);
            end else begin
                m_phase = PhLose;
                push_ev(KLose, -1);
            end
        end else begin
            case (m_phase)
                PhIdle:  if (e) m_phase = PhStart;
                PhStart: begin
                    m_frames = 0;
                    push_ev(KStart, DEF);
                    m_phase = PhSwing;
                end
                PhSwing: if (e) begin
                    push_ev(KLaunch, DEF);
                    m_phase = PhShoot;
                end
                PhShoot: begin
                    if (c) begin
                        m_loot = lt;
                        push_ev(KGrab, spd_tab[lt]);
                        m_phase = (lt == 0 || lt == 7) ? PhEmpty : PhPull;
                    end else if (r) begin
                        m_phase = PhSwing;
                    end
                end
                PhEmpty: if (r) m_phase = PhSwing;
                PhPull: if (r) begin
                    m_score = add_sat(m_score, val_tab[m_loot]);
                    m_phase = PhSwing;
                end
                PhWin: if (e) begin
                    m_level = (m_level < MAXL) ? m_level + 1 : MAXL;
                    m_phase = PhStart;
                end
                PhLose: if (e) begin
                    m_level = 0;
                    m_score = 0;
                    m_phase = PhStart;
                end
                default: m_phase = PhIdle;
            endcase
        end
    endfunction

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, expv);
        end
    endtask

    task automatic check_ev(input int kind);
        ev_t ev;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d cyc=%0d", kind, cyc_n);
            return;
        end
        ev = exp_q.pop_front();
        if (ev.kind != kind || ev.cyc != cyc_n || int'(score) != ev.score ||
            int'(level) != ev.level || int'(time_left) != ev.tleft ||
            (ev.speed >= 0 && int'(move_speed) != ev.speed)) begin
            errors++;
            $display("FAIL event got kind=%0d cyc=%0d score=%0d level=%0d time=%0d speed=%0d expected kind=%0d cyc=%0d score=%0d level=%0d time=%0d speed=%0d",
                     kind, cyc_n, score, level, time_left, move_speed,
                     ev.kind, ev.cyc, ev.score, ev.level, ev.tleft, ev.speed);
        end
    endtask

    // Monitor: every output pulse and every rise of a win/loss flag is an event.
    logic won_p = 1'b0;
    logic lost_p = 1'b0;
    always @(negedge clk) begin
        cyc_n++;
        if (!resetN) begin
            won_p  = 1'b0;
            lost_p = 1'b0;
        end else begin
            if (start_level)             check_ev(KStart);
            if (is_enter_pressed)        check_ev(KLaunch);
            if (loot_grabbed)            check_ev(KGrab);
            if (level_won && !won_p)     check_ev(KWin);
            if (level_lost && !lost_p)   check_ev(KLose);
            won_p  = level_won;
            lost_p = level_lost;
        end
    end

    function automatic bit rnd_sof();
        return $urandom_range(0, 1) == 1;
    endfunction

    task automatic tick(input bit en, input bit c, input int lt, input bit r, input bit s);
        @(negedge clk);
        enter = en;
        col   = c;
        ltype = 3'(lt);
        ret   = r;
        sof   = s;
        @(posedge clk);
        model_step(en, c, lt, r, s);
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 0, 1'b0, rnd_sof());
    endtask

    task automatic press_enter();
        tick(1'b1, 1'b0, 0, 1'b0, rnd_sof());
        tick(1'b0, 1'b0, 0, 1'b0, rnd_sof());
    endtask

    // One throw of the claw; t < 0 means the claw misses and comes back empty.
    task automatic shot(input int t, input int hold, input int ncol);
        if (m_phase != PhSwing) return;
        tick(1'b0, 1'b1, int'($urandom_range(0, 7)), 1'b0, rnd_sof());
        repeat (hold) tick(1'b1, 1'b0, 0, 1'b0, rnd_sof());
        idle();
        press_enter();
        repeat ($urandom_range(0, 3)) idle();
        if (t >= 0) repeat (ncol) tick(1'b0, 1'b1, t, 1'b0, rnd_sof());
        repeat ($urandom_range(0, 3)) idle();
        tick(1'b0, 1'b0, 0, 1'b1, rnd_sof());
        idle();
    endtask

    task automatic finish_level();
        int n;
        n = 0;
        while (!(m_phase == PhWin || m_phase == PhLose) && n < 4000) begin
            tick(1'b0, 1'b0, 0, 1'b0, 1'b1);
            n++;
        end
        if (n >= 4000) begin
            checks++;
            errors++;
            $display("FAIL level_timeout phase=%0d frames=%0d", m_phase, m_frames);
        end
        idle();
    endtask

    task automatic pull_to_expiry();
        if (m_phase != PhSwing) return;
        press_enter();
        tick(1'b0, 1'b1, 3, 1'b0, rnd_sof());
        finish_level();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        chk("queue_drained_before_reset", exp_q.size(), 0);
        resetN = 1'b0;
        enter  = 1'b0;
        col    = 1'b0;
        ret    = 1'b0;
        sof    = 1'b0;
        ltype  = 3'd0;
        #1;
        chk("rst_start_level", int'(start_level), 0);
        chk("rst_is_enter_pressed", int'(is_enter_pressed), 0);
        chk("rst_loot_grabbed", int'(loot_grabbed), 0);
        chk("rst_move_speed", int'(move_speed), DEF);
        chk("rst_score", int'(score), 0);
        chk("rst_time_left", int'(time_left), LT);
        chk("rst_level", int'(level), 0);
        chk("rst_level_won", int'(level_won), 0);
        chk("rst_level_lost", int'(level_lost), 0);
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog cyc=%0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 resetN = 1'b0;
        model_reset();
        do_reset();

        // Level 0: big gold held 5 cycles plus two bags -> 700 -> win.
        press_enter();
        idle();
        shot(2, 100, 5);
        shot(6, int'($urandom_range(1, 4)), int'($urandom_range(1, 5)));
        shot(6, int'($urandom_range(1, 4)), int'($urandom_range(1, 5)));
        finish_level();
        press_enter();
        idle();

        // Level 1 with no loot: 700 < 1000 -> loss, then back to level 0.
        finish_level();
        press_enter();
        idle();

        // Bag scored, then a diamond still on the hook at expiry is discarded.
        shot(6, 1, int'($urandom_range(1, 5)));
        pull_to_expiry();
        press_enter();
        idle();

        // Random level: misses, border, reserved and every loot type.
        repeat (8) begin
            shot(int'($urandom_range(0, 8)) - 1, int'($urandom_range(1, 3)),
                 int'($urandom_range(1, 5)));
        end
        finish_level();
        press_enter();
        idle();

        // Diamond run drives the score into saturation.
        for (int i = 0; i < 115; i++) begin
            shot(3, 1, int'($urandom_range(1, 3)));
        end
        finish_level();

        // Saturated score wins every level; the level index climbs and clamps.
        for (int i = 0; i < 10; i++) begin
            press_enter();
            idle();
            finish_level();
        end
        press_enter();
        idle();

        // Reset while a diamond is being pulled.
        press_enter();
        tick(1'b0, 1'b1, 3, 1'b0, rnd_sof());
        idle();
        idle();
        do_reset();

        press_enter();
        idle();
        shot(0, 1, 2);
        shot(7, 1, 1);
        shot(-1, 2, 1);
        shot(int'($urandom_range(1, 6)), 1, 3);
        idle();
        idle();
        @(negedge clk);
        #1;
        chk("queue_drained_at_end", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
